port_match_arbiter: RTL and testbench

- Shares one SRAM matcher among NUM_PORTS write frontends.
- Each frontend holds a level match request (length, dest port, priority) until it receives a one-cycle match_end pulse.
- The arbiter picks one requester round-robin, issues a start pulse to the shared matcher, and waits for done or timeout.
- It then returns the matched SRAM index (or a fail flag) to the winner only.

---
 rtl/port_match_arbiter.sv | 169 ++++++++++++++++
 tb/tb_port_match_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/port_match_arbiter.sv
// rtl/port_match_arbiter.sv - round-robin share of one SRAM matcher among NUM_PORTS frontends; PRIO_ARB_EN selects priority-first arbitration
module port_match_arbiter #(
    parameter int NUM_PORTS = 16,
    parameter int SRAM_W    = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORTS-1:0]         req_vld,
    input  logic [NUM_PORTS*9-1:0]       req_length,
    input  logic [NUM_PORTS*4-1:0]       req_dest,
    input  logic [NUM_PORTS*3-1:0]       req_prior,
    output logic [NUM_PORTS-1:0]         match_end,
    output logic                         match_fail,
    output logic [SRAM_W-1:0]            match_sram,
    output logic                         mt_start,
    output logic [8:0]                   mt_length,
    output logic [3:0]                   mt_dest,
    output logic [$clog2(NUM_PORTS)-1:0] mt_port,
    input  logic                         mt_done,
    input  logic [SRAM_W-1:0]            mt_sram,
    output logic                         busy
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [8:0]            mt_length_q, mt_length_d;
    logic [3:0]            mt_dest_q, mt_dest_d;
    logic [PW-1:0]         mt_port_q, mt_port_d;
    logic [NUM_PORTS-1:0]  match_end_q, match_end_d;
    logic                  match_fail_q, match_fail_d;
    logic [SRAM_W-1:0]     match_sram_q, match_sram_d;

    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic [PW-1:0]         scan_idx;

`ifdef PRIO_ARB_EN
    logic [2:0]            win_prior;

    // Scan in round-robin order; a strictly higher priority replaces the
    // current pick, so ties keep the first requester seen from rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_prior = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = rr_ptr_q + PW'(i);
            if (req_vld[scan_idx] &&
                (!win_found || req_prior[3*scan_idx +: 3] > win_prior)) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
                win_prior = req_prior[3*scan_idx +: 3];
            end
        end
    end
`else
    logic                  unused_prior;
    assign unused_prior = ^req_prior;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = rr_ptr_q + PW'(i);
            if (req_vld[scan_idx] && !win_found) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        mt_length_d  = mt_length_q;
        mt_dest_d    = mt_dest_q;
        mt_port_d    = mt_port_q;
        match_end_d  = match_end_q;
        match_fail_d = match_fail_q;
        match_sram_d = match_sram_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    mt_length_d = req_length[9*win_idx +: 9];
                    mt_dest_d   = req_dest[4*win_idx +: 4];
                    mt_port_d   = win_idx;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Done is checked first so a result landing on the expiry cycle is kept.
                if (mt_done) begin
                    match_end_d  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << mt_port_q;
                    match_fail_d = 1'b0;
                    match_sram_d = mt_sram;
                    state_d      = S_HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 2)) begin
                    match_end_d  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << mt_port_q;
                    match_fail_d = 1'b1;
                    match_sram_d = '0;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                match_end_d  = '0;
                match_fail_d = 1'b0;
                match_sram_d = '0;
                rr_ptr_d     = mt_port_q + 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            mt_length_q  <= '0;
            mt_dest_q    <= '0;
            mt_port_q    <= '0;
            match_end_q  <= '0;
            match_fail_q <= 1'b0;
            match_sram_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            mt_length_q  <= mt_length_d;
            mt_dest_q    <= mt_dest_d;
            mt_port_q    <= mt_port_d;
            match_end_q  <= match_end_d;
            match_fail_q <= match_fail_d;
            match_sram_q <= match_sram_d;
        end
    end

    assign mt_start   = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign mt_length  = mt_length_q;
    assign mt_dest    = mt_dest_q;
    assign mt_port    = mt_port_q;
    assign match_end  = match_end_q;
    assign match_fail = match_fail_q;
    assign match_sram = match_sram_q;

endmodule

// File: tb/tb_port_match_arbiter.sv
// tb/tb_port_match_arbiter.sv - scoreboard bench for port_match_arbiter
module tb_port_match_arbiter;

    localparam int N  = 16;
    localparam int SW = 5;
    localparam int TO = 64;
    localparam int PW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_vld = '0;
    logic [N*9-1:0]    req_length = '0;
    logic [N*4-1:0]    req_dest = '0;
    logic [N*3-1:0]    req_prior = '0;
    logic [N-1:0]      match_end;
    logic              match_fail;
    logic [SW-1:0]     match_sram;
    logic              mt_start;
    logic [8:0]        mt_length;
    logic [3:0]        mt_dest;
    logic [PW-1:0]     mt_port;
    logic              mt_done = 1'b0;
    logic [SW-1:0]     mt_sram = '0;
    logic              busy;

    port_match_arbiter #(.NUM_PORTS(N), .SRAM_W(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_length(req_length), .req_dest(req_dest), .req_prior(req_prior),
        .match_end(match_end), .match_fail(match_fail), .match_sram(match_sram),
        .mt_start(mt_start), .mt_length(mt_length), .mt_dest(mt_dest), .mt_port(mt_port),
        .mt_done(mt_done), .mt_sram(mt_sram), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int port; int delay; int sram; } grant_t;
    typedef struct { int mask; int fail; int sram; int lat; } result_t;

    grant_t  gq[$];
    result_t rq[$];
    int req_cnt[N];
    int prior_v[N];
    int total = 0;
    int bad = 0;
    int cycle = 0;
    int start_cyc = -100;
    int last_start = -1;
    int done_at = -1;
    int done_sram = 0;

    function automatic int len_of(int i);
        return 20 + 7 * i;
    endfunction

    function automatic int dest_of(int i);
        return (3 * i + 1) % 16;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            req_vld[i]           = (req_cnt[i] > 0);
            req_length[9*i +: 9] = 9'(len_of(i));
            req_dest[4*i +: 4]   = 4'(dest_of(i));
            req_prior[3*i +: 3]  = 3'(prior_v[i]);
        end
    endtask

    task automatic push(int port, int delay, int sram, int fail);
        grant_t  g;
        result_t r;
        g.port = port; g.delay = delay; g.sram = sram;
        r.mask = 1 << port; r.fail = fail;
        r.sram = fail ? 0 : sram;
        r.lat  = (delay < 0) ? TO : delay + 1;
        gq.push_back(g);
        rq.push_back(r);
    endtask

    // One clock of bench activity: sample at negedge, model the matcher and frontends.
    task automatic cyc();
        grant_t  g;
        result_t r;
        @(negedge clk);
        cycle++;
        mt_done = 1'b0;
        mt_sram = '0;
        if (mt_start) begin
            if (gq.size() == 0) begin
                chk("unexp_start", mt_start, 0);
            end else begin
                g = gq.pop_front();
                chk("mt_port", mt_port, g.port);
                chk("mt_length", mt_length, len_of(g.port));
                chk("mt_dest", mt_dest, dest_of(g.port));
                if (last_start >= 0) chk("start_gap", (cycle - last_start) >= 4, 1);
                last_start = cycle;
                start_cyc  = cycle;
                done_at    = (g.delay < 0) ? -1 : cycle + g.delay;
                done_sram  = g.sram;
            end
        end
        if (cycle == done_at) begin
            mt_done = 1'b1;
            mt_sram = SW'(done_sram);
            done_at = -1;
        end
        if (match_end != '0) begin
            if (rq.size() == 0) begin
                chk("unexp_end", match_end, 0);
            end else begin
                r = rq.pop_front();
                chk("match_end", match_end, r.mask);
                chk("match_fail", match_fail, r.fail);
                chk("match_sram", match_sram, r.sram);
                chk("end_latency", cycle - start_cyc, r.lat);
            end
            for (int i = 0; i < N; i++)
                if (match_end[i] && req_cnt[i] > 0) req_cnt[i]--;
        end
        drive_req();
    endtask

    task automatic run(int max);
        int n = 0;
        while ((gq.size() + rq.size()) > 0 && n < max) begin
            cyc();
            n++;
        end
        chk("drain_left", gq.size() + rq.size(), 0);
        repeat (3) cyc();
        chk("busy_idle", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_match_end", match_end, 0);
        chk("rst_match_fail", match_fail, 0);
        chk("rst_match_sram", match_sram, 0);
        chk("rst_mt_start", mt_start, 0);
        chk("rst_mt_length", mt_length, 0);
        chk("rst_mt_dest", mt_dest, 0);
        chk("rst_mt_port", mt_port, 0);
        chk("rst_busy", busy, 0);
        done_at    = -1;
        last_start = -1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_cnt[i] = 0;
            prior_v[i] = 0;
        end
        drive_req();
        do_reset();

        // single request, done 3 cycles after start
        push(2, 3, 19, 0);
        req_cnt[2] = 1;
        run(50);

        // stray mt_done while idle must do nothing
        @(negedge clk);
        mt_done = 1'b1;
        mt_sram = 5'd31;
        repeat (3) cyc();
        chk("stray_done_end", match_end, 0);
        chk("stray_done_busy", busy, 0);

        // round robin over ports 0, 5, 15 from rr_ptr=0
        do_reset();
        push(0, 1, 3, 0);
        push(5, 1, 11, 0);
        push(15, 1, 29, 0);
        push(0, 1, 6, 0);
        req_cnt[0] = 2; req_cnt[5] = 1; req_cnt[15] = 1;
        run(100);

        // timeout on port 3, then a normal grant to port 4
        push(3, -1, 0, 1);
        push(4, 2, 7, 0);
        req_cnt[3] = 1; req_cnt[4] = 1;
        run(300);

        // done on the final WAIT cycle wins over expiry
        push(8, TO - 1, 22, 0);
        req_cnt[8] = 1;
        run(300);

        // reset while port 9 waits; port 0 then beats port 9
        req_cnt[9] = 1;
        gq.push_back('{port: 9, delay: -1, sram: 0});
        repeat (6) cyc();
        chk("rst_grant_seen", gq.size(), 0);
        chk("rst_waiting", busy, 1);
        req_cnt[0] = 1;
        push(0, 2, 4, 0);
        push(9, 2, 9, 0);
        drive_req();
        do_reset();
        run(100);

        // priority contest: ports 1 (p2), 6 (p5), 12 (p5)
        do_reset();
        prior_v[1] = 2; prior_v[6] = 5; prior_v[12] = 5;
`ifdef PRIO_ARB_EN
        push(6, 1, 12, 0);
        push(12, 1, 17, 0);
        push(1, 1, 25, 0);
`else
        push(1, 1, 25, 0);
        push(6, 1, 12, 0);
        push(12, 1, 17, 0);
`endif
        req_cnt[1] = 1; req_cnt[6] = 1; req_cnt[12] = 1;
        run(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
